bch_serial_encoder: RTL and testbench

// - Bit-serial systematic BCH(15,7) double-error-correcting encoder; sits directly upstream of bch_decoder.
// - Accepts a 7-bit message on a valid/ready handshake and computes 8 parity bits with an LFSR over 7 cycles.
// - Presents the 15-bit codeword on a second valid/ready handshake.
// - Codeword layout matches the decoder: codeword[14:8] = message, codeword[7:0] = parity.

---
 rtl/bch15_7_pkg.sv | 17 +
 rtl/bch15_7_lfsr.sv | 31 +++
 rtl/bch_serial_encoder.sv | 116 +++++++++++
 tb/tb_bch_serial_encoder.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bch15_7_pkg.sv
// Shared constants and FSM encoding for the BCH(15,7) encoder/decoder family.
package bch15_7_pkg;

  localparam int N   = 15;
  localparam int K   = 7;
  localparam int PAR = 8;

  // g(x) = x^8 + x^7 + x^6 + x^4 + 1 = m1(x) * m3(x) over GF(16); bit 8 is implicit.
  localparam logic [8:0] GEN_POLY = 9'h1D1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bch15_7_lfsr.sv
// Serial parity LFSR: divides the serially presented polynomial (times x^8) by g(x).
// Also usable for serial syndrome generation.
module bch15_7_lfsr
  import bch15_7_pkg::*;
#(
  parameter logic [8:0] POLY = bch15_7_pkg::GEN_POLY
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           en,
  input  logic           din,
  output logic [PAR-1:0] parity
);

  logic fb;

  assign fb = din ^ parity[PAR-1];

  // Clear on a new word, otherwise one division step per enabled cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity <= '0;
    end else if (clr) begin
      parity <= '0;
    end else if (en) begin
      parity <= {parity[PAR-2:0], 1'b0} ^ (fb ? POLY[PAR-1:0] : {PAR{1'b0}});
    end
  end

endmodule

// File: rtl/bch_serial_encoder.sv
// Bit-serial systematic BCH(15,7) encoder with valid/ready handshakes on both sides.
// Codeword layout: {message[6:0], parity[7:0]}.
module bch_serial_encoder
  import bch15_7_pkg::*;
#(
  parameter logic [8:0] GEN_POLY = bch15_7_pkg::GEN_POLY,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_message,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_codeword,
  output logic             busy,
  output logic [CNT_W-1:0] enc_count
);

  state_t         state;
  state_t         state_nxt;
  logic [2:0]     cnt;
  logic [K-1:0]   msg_reg;
  logic [K-1:0]   shreg;
  logic [PAR-1:0] parity;
  logic           accept;
  logic           shift_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign accept   = in_valid && (state == IDLE);
  assign shift_en = (state == SHIFT);

  bch15_7_lfsr #(
    .POLY (GEN_POLY)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept),
    .en     (shift_en),
    .din    (shreg[K-1]),
    .parity (parity)
  );

  assign out_codeword = {msg_reg, parity};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs, decoded from state only on the input side.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == 3'd6) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  // Message capture, MSB-first message shifter and bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msg_reg <= '0;
      shreg   <= '0;
      cnt     <= '0;
    end else if (accept) begin
      msg_reg <= in_message;
      shreg   <= in_message;
      cnt     <= '0;
    end else if (shift_en) begin
      shreg   <= {shreg[K-2:0], 1'b0};
      cnt     <= cnt + 3'd1;
    end
  end

  // Count codewords taken downstream, holding at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_count <= '0;
    end else if (out_valid && out_ready) begin
      enc_count <= sat_inc(enc_count);
    end
  end

endmodule

// File: tb/tb_bch_serial_encoder.sv
// Self-checking bench for bch_serial_encoder against a polynomial-division reference.
module tb_bch_serial_encoder;

  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_message;
  logic          out_valid;
  logic          out_ready;
  logic [14:0]   out_codeword;
  logic          busy;
  logic [CW-1:0] enc_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  bch_serial_encoder #(
    .GEN_POLY (9'h1D1),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_message   (in_message),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_codeword (out_codeword),
    .busy         (busy),
    .enc_count    (enc_count)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Remainder of a 15-bit polynomial modulo g(x) by long division.
  function automatic logic [7:0] rem15(input logic [14:0] v);
    logic [14:0] r;
    logic [14:0] g;
    r = v;
    g = 15'h01D1;
    for (int i = 14; i >= 8; i--) begin
      if (r[i]) r = r ^ (g << (i - 8));
    end
    return r[7:0];
  endfunction

  function automatic logic [14:0] ref_codeword(input logic [6:0] m);
    logic [14:0] shifted;
    shifted = {m, 8'h00};
    return {m, rem15(shifted)};
  endfunction

  // Minimum-distance decode by exhaustive search over error weights 0..2.
  function automatic logic [6:0] ref_decode(input logic [14:0] rx);
    logic [14:0] e;
    if (rem15(rx) == 8'h00) return rx[14:8];
    for (int i = 0; i < 15; i++) begin
      e = 15'd1 << i;
      if (rem15(rx ^ e) == 8'h00) return rx[14:8] ^ e[14:8];
    end
    for (int i = 0; i < 15; i++) begin
      for (int j = i + 1; j < 15; j++) begin
        e = (15'd1 << i) | (15'd1 << j);
        if (rem15(rx ^ e) == 8'h00) return rx[14:8] ^ e[14:8];
      end
    end
    return rx[14:8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_handshake();
    if (exp_count < MAXC) exp_count++;
  endtask

  // Present one message, wait for out_valid; noisy drives random in_valid during SHIFT.
  task automatic send_word(input logic [6:0] m, input bit noisy,
                           output logic [14:0] cw, output int lat);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    in_valid   = 1'b1;
    in_message = m;
    tick();
    in_valid   = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      if (noisy) begin
        in_valid   = 1'($urandom_range(0, 1));
        in_message = 7'($urandom);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    cw = out_codeword;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_message = 7'h00;
    out_ready  = 1'b0;
    tick();
    tick();
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
               in_ready, out_valid, busy);
    end
    vec_cnt++;
    if (out_codeword !== 15'h0000 || enc_count !== '0) begin
      err_cnt++;
      $display("FAIL reset_data: codeword=%h count=%0d, required 0000 0",
               out_codeword, enc_count);
    end
    rst_n = 1'b1;
    exp_count = 0;
    tick();
  endtask

  task automatic check_known(input logic [6:0] m, input logic [14:0] req);
    logic [14:0] cw;
    int lat;
    out_ready = 1'b1;
    send_word(m, 1'b0, cw, lat);
    vec_cnt++;
    if (lat !== 7) begin
      err_cnt++;
      $display("FAIL latency_%h: %0d cycles, required 7", m, lat);
    end
    vec_cnt++;
    if (cw !== req || out_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL codeword_%h: got %h valid=%b, required %h valid=1", m, cw, out_valid, req);
    end
    tick();
    model_handshake();
    vec_cnt++;
    if (enc_count !== CW'(exp_count) || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL after_hs_%h: count=%0d in_ready=%b out_valid=%b, required %0d 1 0",
               m, enc_count, in_ready, out_valid, exp_count);
    end
  endtask

  task automatic test_known_vectors();
    check_known(7'h00, 15'h0000);
    check_known(7'h01, 15'h01D1);
    check_known(7'h02, ref_codeword(7'h02));
    check_known(7'h7F, 15'h7FFF);
  endtask

  task automatic test_backpressure();
    logic [14:0] cw;
    logic [6:0]  m;
    int lat;
    m = 7'h5A;
    out_ready = 1'b0;
    send_word(m, 1'b0, cw, lat);
    vec_cnt++;
    if (cw !== ref_codeword(m)) begin
      err_cnt++;
      $display("FAIL bp_codeword: got %h, required %h", cw, ref_codeword(m));
    end
    for (int i = 0; i < 20; i++) begin
      in_valid   = 1'b1;
      in_message = 7'($urandom);
      tick();
      vec_cnt++;
      if (out_valid !== 1'b1 || out_codeword !== cw || in_ready !== 1'b0 || busy !== 1'b1) begin
        err_cnt++;
        $display("FAIL bp_hold_%0d: valid=%b cw=%h in_ready=%b busy=%b, required 1 %h 0 1",
                 i, out_valid, out_codeword, in_ready, busy, cw);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    model_handshake();
    vec_cnt++;
    if (enc_count !== CW'(exp_count) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_release: count=%0d valid=%b in_ready=%b, required %0d 0 1",
               enc_count, out_valid, in_ready, exp_count);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [14:0] cw;
    int lat;
    bit seen;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_message = 7'h33;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    exp_count = 0;
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || enc_count !== '0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_reset: in_ready=%b valid=%b count=%0d busy=%b, required 1 0 0 0",
               in_ready, out_valid, enc_count, busy);
    end
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    vec_cnt++;
    if (seen !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_reset_no_valid: out_valid pulsed=%b, required 0", seen);
    end
    send_word(7'h01, 1'b0, cw, lat);
    vec_cnt++;
    if (cw !== 15'h01D1) begin
      err_cnt++;
      $display("FAIL post_reset_word: got %h, required 01d1", cw);
    end
    tick();
    model_handshake();
    vec_cnt++;
    if (enc_count !== CW'(exp_count)) begin
      err_cnt++;
      $display("FAIL post_reset_count: %0d, required %0d", enc_count, exp_count);
    end
  endtask

  task automatic test_random_closed_loop();
    logic [14:0] cw;
    logic [14:0] rx;
    logic [6:0]  m;
    int lat;
    int hold;
    int nflip;
    int p0;
    int p1;
    for (int n = 0; n < 1000; n++) begin
      m    = 7'($urandom);
      hold = $urandom_range(0, 3);
      out_ready = (hold == 0);
      send_word(m, 1'b1, cw, lat);
      vec_cnt++;
      if (cw !== ref_codeword(m) || lat !== 7) begin
        err_cnt++;
        $display("FAIL rnd_word_%0d: msg=%h cw=%h lat=%0d, required %h lat 7",
                 n, m, cw, lat, ref_codeword(m));
      end
      for (int h = 0; h < hold; h++) tick();
      out_ready = 1'b1;
      tick();
      model_handshake();
      vec_cnt++;
      if (enc_count !== CW'(exp_count)) begin
        err_cnt++;
        $display("FAIL rnd_count_%0d: %0d, required %0d", n, enc_count, exp_count);
      end
      nflip = $urandom_range(0, 2);
      p0 = $urandom_range(0, 14);
      p1 = (p0 + $urandom_range(1, 14)) % 15;
      rx = cw;
      if (nflip >= 1) rx[p0] = ~rx[p0];
      if (nflip == 2) rx[p1] = ~rx[p1];
      vec_cnt++;
      if ((rem15(rx) != 8'h00) !== (nflip != 0)) begin
        err_cnt++;
        $display("FAIL rnd_detect_%0d: syndrome=%h flips=%0d", n, rem15(rx), nflip);
      end
      vec_cnt++;
      if (ref_decode(rx) !== m) begin
        err_cnt++;
        $display("FAIL rnd_decode_%0d: decoded %h, required %h", n, ref_decode(rx), m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_backpressure();
    test_reset_mid_shift();
    test_random_closed_loop();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
